// File: rtl/ref_row_fetch_pkg.sv
// Shared types and constants for the reference-row fetch path and the window shift register.
package ref_row_fetch_pkg;

  localparam int unsigned ROWS_DEFAULT = 15;
  localparam int unsigned ROW_W        = 64;
  localparam int unsigned CNT_W        = 4;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StPad,
    StFin
  } state_e;

  // Rows actually read from memory: 0 means one row, anything past the window is the window.
  function automatic logic [CNT_W-1:0] clamp_rows(input logic [CNT_W-1:0] v,
                                                  input int unsigned      rows);
    if (v == '0) return CNT_W'(1);
    if (32'(v) > rows) return CNT_W'(rows);
    return v;
  endfunction

endpackage

// File: rtl/ref_addr_gen.sv
// Running read address, request counter and outstanding-read throttle for ref_row_fetch.
module ref_addr_gen
  import ref_row_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic              clock,
  input  logic              reset_L,
  input  logic              load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic              fetching,
  input  logic [CNT_W-1:0]  n_fetch,
  input  logic [CNT_W-1:0]  rsp_cnt,
  input  logic              mem_gnt,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]  outstanding;

  assign outstanding = req_cnt_q - rsp_cnt;
  // Decoded from registers only, so it is stable for the whole cycle until granted.
  assign mem_req  = fetching && (req_cnt_q < n_fetch) && (32'(outstanding) < MAX_OUT);
  assign mem_addr = addr_q;

  always_comb begin
    addr_d    = addr_q;
    req_cnt_d = req_cnt_q;
    if (load) begin
      addr_d    = base_addr;
      req_cnt_d = '0;
    end else if (mem_req && mem_gnt) begin
      addr_d    = addr_q + stride;
      req_cnt_d = req_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      addr_q    <= '0;
      req_cnt_q <= '0;
    end else begin
      addr_q    <= addr_d;
      req_cnt_q <= req_cnt_d;
    end
  end

endmodule

// File: rtl/ref_row_fetch.sv
// Fetches a window of reference rows and strobes them into the window shift register.
// Optional bottom-edge padding is enabled with the ROW_PAD_EN macro.
module ref_row_fetch
  import ref_row_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned ROWS    = ROWS_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_L,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [3:0]        valid_rows,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [ROW_W-1:0]  mem_rdata,
  output logic [ROW_W-1:0]  row_data,
  output logic              row_load_L,
  output logic [3:0]        row_idx
);

  localparam logic [CNT_W-1:0] ROWS_C = CNT_W'(ROWS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rsp_cnt_q, rsp_cnt_d;
  logic [CNT_W-1:0] n_fetch_q, n_fetch_new;
  logic [CNT_W-1:0] row_idx_q, row_idx_d;
  logic [ROW_W-1:0] row_data_q, row_data_d;
  logic             row_load_L_q, row_load_L_d;
  logic             busy_q, done_q;
  logic             start_ok;

  assign start_ok = start && (state_q == StIdle);

`ifdef ROW_PAD_EN
  assign n_fetch_new = clamp_rows(valid_rows, ROWS);
`else
  logic unused_valid_rows;
  assign unused_valid_rows = ^valid_rows;
  assign n_fetch_new       = ROWS_C;
`endif

  ref_addr_gen #(
    .ADDR_W  (ADDR_W),
    .MAX_OUT (MAX_OUT)
  ) u_addr_gen (
    .clock     (clock),
    .reset_L   (reset_L),
    .load      (start_ok),
    .base_addr (base_addr),
    .stride    (stride),
    .fetching  (state_q == StFetch),
    .n_fetch   (n_fetch_q),
    .rsp_cnt   (rsp_cnt_q),
    .mem_gnt   (mem_gnt),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr)
  );

  always_comb begin
    state_d      = state_q;
    rsp_cnt_d    = rsp_cnt_q;
    row_data_d   = row_data_q;
    row_idx_d    = row_idx_q;
    row_load_L_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StFetch;
          rsp_cnt_d = '0;
        end
      end
      StFetch: begin
        if (rsp_cnt_q == ROWS_C) begin
          state_d = StFin;
        end else if (rsp_cnt_q == n_fetch_q) begin
          // First padded row goes out on the transition so strobes stay back to back.
          state_d      = StPad;
          row_load_L_d = 1'b0;
          row_idx_d    = rsp_cnt_q;
          rsp_cnt_d    = rsp_cnt_q + CNT_W'(1);
        end else if (mem_rvalid) begin
          row_data_d   = mem_rdata;
          row_idx_d    = rsp_cnt_q;
          row_load_L_d = 1'b0;
          rsp_cnt_d    = rsp_cnt_q + CNT_W'(1);
        end
      end
      StPad: begin
        if (rsp_cnt_q == ROWS_C) begin
          state_d = StFin;
        end else begin
          row_load_L_d = 1'b0;
          row_idx_d    = rsp_cnt_q;
          rsp_cnt_d    = rsp_cnt_q + CNT_W'(1);
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= StIdle;
      rsp_cnt_q    <= '0;
      n_fetch_q    <= '0;
      row_data_q   <= '0;
      row_idx_q    <= '0;
      row_load_L_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rsp_cnt_q    <= rsp_cnt_d;
      row_data_q   <= row_data_d;
      row_idx_q    <= row_idx_d;
      row_load_L_q <= row_load_L_d;
      busy_q       <= (state_d != StIdle);
      done_q       <= (state_d == StFin);
      if (start_ok) n_fetch_q <= n_fetch_new;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign row_data   = row_data_q;
  assign row_load_L = row_load_L_q;
  assign row_idx    = row_idx_q;

endmodule

// File: tb/tb_ref_row_fetch.sv
// Directed bench for ref_row_fetch: in-order memory model with configurable latency and grant stalls.
`timescale 1ns/1ps
module tb_ref_row_fetch;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned MAX_OUT = 4;
  localparam int unsigned ROWS    = 15;

  logic              clock = 1'b0;
  logic              reset_L = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       base_addr = '0;
  logic [31:0]       stride = '0;
  logic [3:0]        valid_rows = 4'd15;
  logic              busy, done, mem_req, row_load_L;
  logic [31:0]       mem_addr;
  logic              mem_gnt = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [63:0]       mem_rdata = '0;
  logic [63:0]       row_data;
  logic [3:0]        row_idx;

  ref_row_fetch #(
    .ADDR_W  (ADDR_W),
    .MAX_OUT (MAX_OUT),
    .ROWS    (ROWS)
  ) dut (
    .clock      (clock),
    .reset_L    (reset_L),
    .start      (start),
    .base_addr  (base_addr),
    .stride     (stride),
    .valid_rows (valid_rows),
    .busy       (busy),
    .done       (done),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .row_data   (row_data),
    .row_load_L (row_load_L),
    .row_idx    (row_idx)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, a};
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } pend_t;

  pend_t       pend_q[$];
  int          cyc = 0;
  int          lat = 2;
  bit          rand_gnt = 1'b0;
  int          n_req = 0, n_strb = 0, n_done = 0;
  int          out_cnt = 0, max_out_seen = 0, viol_out = 0, viol_hold = 0;
  logic [31:0] req_addr[64];
  logic [3:0]  strb_idx[64];
  logic [63:0] strb_data[64];
  int          strb_cyc[64];
  int          done_cyc = 0;
  logic        done_load_L = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor and in-order memory model, all on the falling edge.
  always @(negedge clock) begin
    if (!row_load_L && n_strb < 64) begin
      strb_idx[n_strb]  = row_idx;
      strb_data[n_strb] = row_data;
      strb_cyc[n_strb]  = cyc;
      n_strb++;
    end
    if (done) begin
      n_done++;
      done_cyc    = cyc;
      done_load_L = row_load_L;
    end
    if (reset_L && prev_stall && (!mem_req || mem_addr !== prev_addr)) viol_hold++;
    if (mem_req && out_cnt >= int'(MAX_OUT)) viol_out++;
    mem_gnt = rand_gnt ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (mem_req && mem_gnt) begin
      if (n_req < 64) req_addr[n_req] = mem_addr;
      n_req++;
      pend_q.push_back('{addr: mem_addr, ready: cyc + lat});
      out_cnt++;
    end
    prev_stall = reset_L && mem_req && !mem_gnt;
    prev_addr  = mem_addr;
    if (pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
      out_cnt--;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = {$urandom, $urandom};
    end
    if (out_cnt > max_out_seen) max_out_seen = out_cnt;
  end

  task automatic check_reset_vals(input string tag);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
    check({tag, " mem_req"}, 64'(mem_req), 64'd0);
    check({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, " row_data"}, row_data, 64'd0);
    check({tag, " row_load_L"}, 64'(row_load_L), 64'd1);
    check({tag, " row_idx"}, 64'(row_idx), 64'd0);
  endtask

  task automatic run_window(input string tag, input logic [31:0] base, input logic [31:0] strd,
                            input int n_fetch, input bit dup_start);
    int bad_addr, bad_row, last;
    logic [31:0] a;
    n_req = 0; n_strb = 0; n_done = 0; max_out_seen = 0; viol_out = 0; viol_hold = 0;
    base_addr = base;
    stride    = strd;
    start     = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check({tag, " busy after start"}, 64'(busy), 64'd1);
    check({tag, " first mem_req"}, 64'(mem_req), 64'd1);
    if (dup_start) begin
      base_addr = 32'h5555_0000;
      start     = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (6) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    for (int i = 0; i < 3000 && n_done == 0; i++) @(negedge clock);
    @(negedge clock);
    check({tag, " done pulses"}, 64'(n_done), 64'd1);
    check({tag, " requests"}, 64'(n_req), 64'(n_fetch));
    bad_addr = 0;
    for (int i = 0; i < n_fetch && i < n_req; i++) begin
      a = base + 32'(i) * strd;
      if (req_addr[i] !== a) bad_addr++;
    end
    check({tag, " address sequence errors"}, 64'(bad_addr), 64'd0);
    check({tag, " strobes"}, 64'(n_strb), 64'(ROWS));
    bad_row = 0;
    for (int i = 0; i < int'(ROWS) && i < n_strb; i++) begin
      a = base + 32'((i < n_fetch) ? i : n_fetch - 1) * strd;
      if (strb_idx[i] !== 4'(i) || strb_data[i] !== mem_word(a)) bad_row++;
    end
    check({tag, " row idx/data errors"}, 64'(bad_row), 64'd0);
    last = (n_strb > 0) ? strb_cyc[n_strb-1] : -100;
    check({tag, " done after last strobe"}, 64'(done_cyc), 64'(last + 1));
    check({tag, " row_load_L in done cycle"}, 64'(done_load_L), 64'd1);
    check({tag, " req with MAX_OUT outstanding"}, 64'(viol_out), 64'd0);
    check({tag, " unheld stalled request"}, 64'(viol_hold), 64'd0);
    check({tag, " busy after done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n_pad;
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    reset_L = 1'b1;
    repeat (2) @(negedge clock);

    lat = 2; rand_gnt = 1'b0;
    run_window("lat2", 32'h0000_1000, 32'h0000_0040, ROWS, 1'b0);
    check("lat2 last address", 64'(req_addr[14]), 64'h1380);
    check("lat2 strobe span", 64'(strb_cyc[14] - strb_cyc[0]), 64'd14);

    lat = 10;
    run_window("lat10", 32'h0000_8000, 32'h0000_0100, ROWS, 1'b0);
    check("lat10 peak outstanding", 64'(max_out_seen), 64'(MAX_OUT));

    lat = 3; rand_gnt = 1'b1;
    run_window("stall", 32'h2000_0000, 32'h0000_0208, ROWS, 1'b0);
    rand_gnt = 1'b0;

    valid_rows = 4'd5;
`ifdef ROW_PAD_EN
    n_pad = 5;
`else
    n_pad = ROWS;
`endif
    run_window("pad5", 32'h0000_4000, 32'h0000_0080, n_pad, 1'b0);
    valid_rows = 4'd15;

    // Reset after the 7th strobe, then let stale responses drain while idle.
    lat = 3;
    n_strb = 0;
    base_addr = 32'h0003_0000;
    stride = 32'h40;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 500 && n_strb < 7; i++) @(negedge clock);
    check("midreset reached 7 strobes", 64'(n_strb >= 7), 64'd1);
    #2 reset_L = 1'b0;
    #1 check_reset_vals("midreset");
    @(negedge clock);
    reset_L = 1'b1;
    n_strb = 0;
    repeat (25) @(negedge clock);
    check("stale rvalid strobes", 64'(n_strb), 64'd0);
    check("stale rvalid busy", 64'(busy), 64'd0);
    run_window("after reset", 32'h0004_0000, 32'h0000_0010, ROWS, 1'b0);

    lat = 2;
    run_window("wrap", 32'hFFFF_FFC0, 32'h0000_0040, ROWS, 1'b1);
    check("wrap second address", 64'(req_addr[1]), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ref_row_fetch.md
# ref_row_fetch

Upstream feeder for the 15-row reference-window shift register in the HEVC sub-pixel interpolation datapath. On a `start` pulse it reads 15 consecutive 64-bit reference rows (8 pixels × 8 bits) from memory at `base_addr + i*stride`. It presents each row on `row_data` with a one-cycle active-low `row_load_L` strobe, in the form the window shift register consumes, and signals `done` when the window is full. Requests are pipelined, with a bounded number outstanding.

## Interface
- ADDR_W, 32, memory address width
- MAX_OUT, 4, maximum outstanding memory reads (1..8)
- ROWS, 15, rows per window (equals the window shift-register depth)

- clock  in  1  system clock, posedge
- reset_L  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begin a window fetch; ignored while busy
- base_addr  in  ADDR_W  address of row 0; sampled on accepted start
- stride  in  ADDR_W  row pitch in address units; sampled on accepted start
- valid_rows  in  4  rows inside the picture; used only with ROW_PAD_EN
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last row strobe
- mem_req  out  1  read request valid
- mem_addr  out  ADDR_W  read address
- mem_gnt  in  1  request accepted this cycle when mem_req && mem_gnt
- mem_rvalid  in  1  read data valid; responses return in request order
- mem_rdata  in  64  read data, pixel 0 in bits [7:0]
- row_data  out  64  row presented to the window shift register
- row_load_L  out  1  active-low strobe, low exactly one cycle per row
- row_idx  out  4  index 0..ROWS-1 of the row on row_data

## Operation
- FSM states: IDLE, FETCH, PAD, FIN.
  - IDLE → FETCH on start. Latch the parameters and clear counters.
  - FETCH → PAD when rsp_cnt == n_fetch and n_fetch < ROWS.
  - FETCH → FIN when rsp_cnt == ROWS.
  - PAD → FIN after the last padded row.
  - FIN → IDLE unconditionally; `done` is high for this single cycle.
- n_fetch = ROWS without the macro. With the macro, n_fetch = clamp(valid_rows, 1, ROWS).
- Request counter `req_cnt` (0..ROWS) and response counter `rsp_cnt` (0..ROWS); outstanding = req_cnt − rsp_cnt.
- mem_req = (state==FETCH) && req_cnt < n_fetch && outstanding < MAX_OUT. It does not depend on same-cycle mem_rvalid.
- mem_addr is held in a running-address register:
  - loaded with base_addr on start;
  - advanced by stride on each grant;
  - wraps modulo 2^ADDR_W.
- mem_addr and mem_req stay stable until granted.
- On mem_rvalid in FETCH:
  - row_data ← mem_rdata;
  - row_idx ← rsp_cnt;
  - row_load_L ← 0 for the next cycle;
  - rsp_cnt increments.
- mem_rvalid in IDLE, PAD or FIN is ignored, including stale responses after reset.
- PAD:
  - row_data holds the last fetched row;
  - row_load_L is low every cycle;
  - row_idx increments from n_fetch to ROWS−1.
- A start pulse while busy is dropped with no effect.

## Timing
- Reset values: busy=0, done=0, mem_req=0, mem_addr=0, row_data=0, row_load_L=1, row_idx=0, state=IDLE, counters=0.
- Reset mid-operation: all of the above apply immediately (asynchronous). In-flight reads are abandoned.
- All outputs are registered, except mem_req, which is decoded from registers only.
- start at edge k → busy and FETCH at k+1; first mem_req visible in cycle k+1.
- mem_rvalid at edge m → row_data/row_load_L valid in cycle m+1. row_data is stable through the whole low phase, so the negedge-sampling shift register captures it.
- Back-to-back rvalid produces back-to-back strobes, one row per cycle. The peak rate is 1 row/clock.
- done is asserted one cycle after the last row_load_L low cycle. row_load_L is high in the done cycle.
- A new start is accepted in the cycle after done, when the block is back in IDLE.

## Configuration
- ROW_PAD_EN defined:
  - rows at index ≥ valid_rows are not fetched;
  - each such row replicates the last in-picture row (HEVC bottom-edge padding);
  - valid_rows=0 is treated as 1; values > ROWS are treated as ROWS.
- ROW_PAD_EN undefined: valid_rows is ignored, all ROWS rows are fetched, and the PAD state is unreachable.

## Structure
- A shared package holds:
  - the FSM state enum;
  - the ROWS default (15) and the row width (64), shared with the window shift register and the output collector.
- One sub-module, `ref_addr_gen`, owns the running address, `req_cnt` and the outstanding check, and emits mem_req/mem_addr.
- The top level owns the FSM, `rsp_cnt`, the padding logic and the row output registers.

## Test plan
- Fixed-latency 2 memory with mem_gnt always high; start with base=0x1000, stride=0x40 → addresses 0x1000..0x1380 in order, 15 strobes with row_idx 0..14, done one cycle after the last strobe.
- Latency 10 with MAX_OUT=4 → mem_req never asserts with 4 outstanding; exactly 15 requests and 15 strobes.
- Random mem_gnt stalls → mem_addr is held while ungranted; no address is skipped or repeated.
- ROW_PAD_EN, valid_rows=5 → 5 reads; rows 5..14 each equal row 4's data; 15 strobes; done.
- Assert reset_L low after the 7th strobe → outputs return to reset values immediately; the next start fetches a full fresh window; stale rvalids are ignored.
- start repeated while busy, and base_addr=0xFFFFFFC0 with stride=0x40 → the extra starts are ignored; the address wraps to 0x00000000.
